// File: rtl/tank_input_pkg.sv
// Shared types and constants for the tank keyboard controller and downstream tank logic.
package tank_input_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCharge,
    StFire,
    StWaitRel
  } tic_state_t;

  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_SPACE = 8'h2C;

  localparam int unsigned CMD_WIDTH = 7;

endpackage

// File: rtl/tank_input_ctrl_if.sv
// Keycode/frame inputs and tank command outputs between the input controller and game logic.
interface tank_input_ctrl_if;
  import tank_input_pkg::*;

  logic [7:0]           keycode;
  logic                 frame_tick;
  logic                 turn_active;
  logic                 fire_ack;
  logic                 move_left;
  logic                 move_right;
  logic [CMD_WIDTH-1:0] angle;
  logic [CMD_WIDTH-1:0] power;
  logic                 charging;
  logic                 fire_req;
  logic [CMD_WIDTH-1:0] fire_angle;
  logic [CMD_WIDTH-1:0] fire_power;

  modport master (
    input  keycode, frame_tick, turn_active, fire_ack,
    output move_left, move_right, angle, power, charging, fire_req, fire_angle, fire_power
  );

  modport slave (
    output keycode, frame_tick, turn_active, fire_ack,
    input  move_left, move_right, angle, power, charging, fire_req, fire_angle, fire_power
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter: load > clear > inc > dec; never wraps past 0 or Max.
module sat_counter #(
  parameter int unsigned Width = 7,
  parameter int unsigned Max   = 90,
  parameter int unsigned Step  = 1,
  parameter int unsigned Init  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] count
);

  localparam logic [Width:0] MaxExt  = (Width+1)'(Max);
  localparam logic [Width:0] StepExt = (Width+1)'(Step);

  logic [Width:0]   sum;
  logic [Width-1:0] count_d;

  always_comb begin
    sum     = {1'b0, count} + StepExt;
    count_d = count;
    if (load) begin
      count_d = load_val;
    end else if (clear) begin
      count_d = '0;
    end else if (inc) begin
      // One extra bit so the overflow is visible before clamping.
      count_d = (sum > MaxExt) ? MaxExt[Width-1:0] : sum[Width-1:0];
    end else if (dec) begin
      count_d = ({1'b0, count} < StepExt) ? '0 : count - StepExt[Width-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) count <= Width'(Init);
    else       count <= count_d;
  end

endmodule

// File: rtl/tank_input_ctrl.sv
// Turns the registered HID keycode into move, aim, charge and fire commands for one tank.
module tank_input_ctrl
  import tank_input_pkg::*;
#(
  parameter int unsigned ANGLE_MAX  = 90,
  parameter int unsigned ANGLE_INIT = 45,
  parameter int unsigned POWER_MAX  = 100,
  parameter int unsigned POWER_STEP = 2
) (
  input logic          Clk,
  input logic          Reset,
  tank_input_ctrl_if.master bus
);

  tic_state_t           state_q, state_d;
  logic [7:0]           kc_q;
  logic                 move_left_q, move_right_q, move_left_d, move_right_d;
  logic                 charging_q, fire_req_q;
  logic [CMD_WIDTH-1:0] fire_angle_q, fire_power_q, angle, power;
  logic                 angle_inc, angle_dec, power_inc, power_clr, latch_fire;
  logic                 space;

  assign space = (kc_q == KC_SPACE);

  always_comb begin
    state_d      = state_q;
    move_left_d  = 1'b0;
    move_right_d = 1'b0;
    angle_inc    = 1'b0;
    angle_dec    = 1'b0;
    power_inc    = 1'b0;
    power_clr    = 1'b0;
    latch_fire   = 1'b0;
    unique case (state_q)
      StIdle: begin
        move_left_d  = bus.turn_active && (kc_q == KC_A);
        move_right_d = bus.turn_active && (kc_q == KC_D);
        angle_inc    = bus.frame_tick && (kc_q == KC_W);
        angle_dec    = bus.frame_tick && (kc_q == KC_S);
        if (bus.turn_active && space) begin
          state_d   = StCharge;
          power_clr = 1'b1;
        end
      end
      StCharge: begin
        // Losing the turn abandons the charge even if Space is released now.
        if (!bus.turn_active) begin
          state_d   = StIdle;
          power_clr = 1'b1;
        end else begin
          power_inc = bus.frame_tick;
          if (!space) begin
            state_d    = StFire;
            latch_fire = 1'b1;
          end
        end
      end
      StFire: begin
        if (bus.fire_ack) begin
          state_d   = StWaitRel;
          power_clr = 1'b1;
        end
      end
      StWaitRel: begin
        if (!space) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      kc_q         <= '0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      charging_q   <= 1'b0;
      fire_req_q   <= 1'b0;
      fire_angle_q <= '0;
      fire_power_q <= '0;
    end else begin
      state_q      <= state_d;
      kc_q         <= bus.keycode;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      charging_q   <= (state_d == StCharge);
      fire_req_q   <= (state_d == StFire);
      if (latch_fire) begin
        fire_angle_q <= angle;
        fire_power_q <= power;
      end
    end
  end

  sat_counter #(
    .Width (CMD_WIDTH),
    .Max   (ANGLE_MAX),
    .Step  (1),
    .Init  (ANGLE_INIT)
  ) u_angle (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (angle_inc),
    .dec      (angle_dec),
    .clear    (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .count    (angle)
  );

  sat_counter #(
    .Width (CMD_WIDTH),
    .Max   (POWER_MAX),
    .Step  (POWER_STEP),
    .Init  (0)
  ) u_power (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (power_inc),
    .dec      (1'b0),
    .clear    (power_clr),
    .load     (1'b0),
    .load_val ('0),
    .count    (power)
  );

  assign bus.move_left  = move_left_q;
  assign bus.move_right = move_right_q;
  assign bus.angle      = angle;
  assign bus.power      = power;
  assign bus.charging   = charging_q;
  assign bus.fire_req   = fire_req_q;
  assign bus.fire_angle = fire_angle_q;
  assign bus.fire_power = fire_power_q;

endmodule
